// File: rtl/code_tx_pkg.sv
// Shared types and constants for the TX code serializer: FSM state encoding,
// default preamble and the frame-length helper.
package code_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GUARD
  } state_t;

  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;

  // Serial bits in one frame: preamble, data, optional parity, guard.
  function automatic int frame_bits(input int code_w, input int pre_w, input bit par);
    return pre_w + code_w + int'(par) + 1;
  endfunction

endpackage

// File: rtl/code_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while run is high and pulses bit_en on the
// last clk of each serial bit. Held at 0 while idle.
module code_bit_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_en = run && (cnt_q == LAST);

endmodule

// File: rtl/code_serializer.sv
// Framed TX serializer: preamble, data (MSB or LSB first), optional even parity,
// one guard bit. Define CODE_SERIALIZER_PARITY_EN to insert the parity bit.
module code_serializer
  import code_tx_pkg::*;
#(
  parameter int              CODE_W    = 8,
  parameter int              PRE_W     = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(DEFAULT_PREAMBLE),
  parameter int              DIV       = 1,
  parameter bit              LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int MAX_W = (PRE_W > CODE_W) ? PRE_W : CODE_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  state_t            state_q;
  logic [CODE_W-1:0] shift_q;
  logic [PRE_W-1:0]  pre_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              bit_en;
  logic              accept;
  logic              data_bit;
  logic [CODE_W-1:0] data_shifted;
`ifdef CODE_SERIALIZER_PARITY_EN
  logic              parity_q;
`endif

  code_bit_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .bit_en (bit_en)
  );

  assign accept = code_valid && code_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    data_bit     = shift_q[CODE_W-1];
    data_shifted = shift_q << 1;
    if (LSB_FIRST) begin
      data_bit     = shift_q[0];
      data_shifted = shift_q >> 1;
    end
  end

  // Decoded from state and timer flops, so it drops with the asynchronous reset.
  assign frame_done = (state_q == GUARD) && bit_en;

  // tx_bit is loaded with the next bit on the edge that ends the current one,
  // so the shift registers always hold the not-yet-sent bits at their head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pre_q      <= '0;
      bit_cnt_q  <= '0;
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      code_ready <= 1'b0;
`ifdef CODE_SERIALIZER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_bit    <= 1'b0;
          tx_active <= 1'b0;
          bit_cnt_q <= '0;
          if (accept) begin
            shift_q    <= code;
`ifdef CODE_SERIALIZER_PARITY_EN
            parity_q   <= ^code;
`endif
            pre_q      <= PREAMBLE << 1;
            tx_bit     <= PREAMBLE[PRE_W-1];
            tx_active  <= 1'b1;
            code_ready <= 1'b0;
            state_q    <= PRE;
          end else begin
            code_ready <= 1'b1;
          end
        end
        PRE: if (bit_en) begin
          if (bit_cnt_q == CNT_W'(PRE_W - 1)) begin
            bit_cnt_q <= '0;
            tx_bit    <= data_bit;
            shift_q   <= data_shifted;
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            tx_bit    <= pre_q[PRE_W-1];
            pre_q     <= pre_q << 1;
          end
        end
        DATA: if (bit_en) begin
          if (bit_cnt_q == CNT_W'(CODE_W - 1)) begin
            bit_cnt_q <= '0;
`ifdef CODE_SERIALIZER_PARITY_EN
            tx_bit    <= parity_q;
            state_q   <= PAR;
`else
            tx_bit    <= 1'b0;
            state_q   <= GUARD;
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            tx_bit    <= data_bit;
            shift_q   <= data_shifted;
          end
        end
        PAR: if (bit_en) begin
          tx_bit  <= 1'b0;
          state_q <= GUARD;
        end
        GUARD: if (bit_en) begin
          tx_active  <= 1'b0;
          code_ready <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_serializer.sv
// Self-checking bench: three serializer instances (DIV=1 MSB-first, DIV=3, LSB-first)
// share one stimulus; each is compared every cycle against a frame-level model.
module tb_code_serializer;
  import code_tx_pkg::*;

  localparam int CODE_W = 8;
  localparam int PRE_W  = 4;
  localparam logic [3:0] PRE = 4'b1010;
`ifdef CODE_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = frame_bits(CODE_W, PRE_W, PAR_EN);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;

  logic ready_w [3];
  logic bit_w   [3];
  logic act_w   [3];
  logic done_w  [3];

  int   checks = 0;
  int   failures = 0;
  int   acc_num  [3];
  int   log_len  [3];
  logic log_mem  [3][64];
  int   fd_idx   [3];
  int   act_cnt  [3];
  int   last_gap [3];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int GDIV = (g == 1) ? 3 : 1;
    localparam bit GLSB = (g == 2);

    code_serializer #(
      .CODE_W(CODE_W), .PRE_W(PRE_W), .PREAMBLE(PRE), .DIV(GDIV), .LSB_FIRST(GLSB)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_valid (code_valid),
      .code       (code),
      .code_ready (ready_w[g]),
      .tx_bit     (bit_w[g]),
      .tx_active  (act_w[g]),
      .frame_done (done_w[g])
    );

    // Model: cyc is the clk index within the current frame, -1 when idle.
    int   cyc = -1;
    bit   exp_ready = 1'b0;
    bit   seq[$];
    int   idle_cnt = 100;
    logic [3:0] got, want;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cyc = -1;
        exp_ready = 1'b0;
      end else if (cyc >= 0) begin
        cyc++;
        if (cyc == GDIV * NB) begin
          cyc = -1;
          exp_ready = 1'b1;
        end
      end else if (exp_ready && code_valid) begin
        seq.delete();
        for (int i = PRE_W - 1; i >= 0; i--) seq.push_back(PRE[i]);
        for (int i = 0; i < CODE_W; i++) seq.push_back(GLSB ? code[i] : code[CODE_W-1-i]);
        if (PAR_EN) seq.push_back(^code);
        seq.push_back(1'b0);
        cyc = 0;
        exp_ready = 1'b0;
        acc_num[g]++;
        log_len[g] = 0;
        act_cnt[g] = 0;
        fd_idx[g] = -1;
      end else begin
        exp_ready = 1'b1;
      end
    end

    always @(negedge clk) begin
      want = {1'b0, cyc >= 0, cyc == GDIV * NB - 1, exp_ready};
      if (cyc >= 0) want[3] = seq[cyc / GDIV];
      got = {bit_w[g], act_w[g], done_w[g], ready_w[g]};
      check($sformatf("inst%0d {bit,active,done,ready}", g), got, want);
      if (act_w[g]) begin
        if (act_cnt[g] == 0) last_gap[g] = idle_cnt;
        if (log_len[g] < 64) begin
          log_mem[g][log_len[g]] = bit_w[g];
          log_len[g]++;
        end
        act_cnt[g]++;
      end else begin
        idle_cnt++;
      end
      if (done_w[g]) begin
        fd_idx[g] = act_cnt[g];
        idle_cnt = 0;
      end
    end
  end

  task automatic wait_all_ready(input string name);
    int n = 0;
    while (!(ready_w[0] && ready_w[1] && ready_w[2]) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " ready timeout"}, n < 400, 1'b1);
  endtask

  task automatic send(input logic [7:0] c);
    wait_all_ready("pre-send");
    code_valid = 1'b1;
    code = c;
    @(posedge clk); #1;
    code_valid = 1'b0;
    @(posedge clk); #1;
    wait_all_ready("post-send");
  endtask

  function automatic logic [63:0] packed_log(input int g, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], log_mem[g][i]};
    return v;
  endfunction

  task automatic wait_accept(input int prev);
    int n = 0;
    while (acc_num[0] == prev && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept timeout", n < 400, 1'b1);
  endtask

  initial begin
    logic [13:0] base;
    logic [63:0] tripled;
    int prev;

    for (int g = 0; g < 3; g++) begin
      acc_num[g] = 0; log_len[g] = 0; fd_idx[g] = -1; act_cnt[g] = 0; last_gap[g] = -1;
    end

    #2;
    for (int g = 0; g < 3; g++)
      check($sformatf("reset outputs inst%0d", g),
            {ready_w[g], bit_w[g], act_w[g], done_w[g]}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready before first edge", ready_w[0], 1'b0);
    @(posedge clk); #1;
    check("ready after first edge", ready_w[0], 1'b1);

    // 8'hA5, MSB first, DIV=1 and DIV=3
    send(8'hA5);
    base = PAR_EN ? 14'b10101010010100 : 14'b01010101001010;
    check("A5 bits inst0", packed_log(0, NB), base);
    check("A5 active clks inst0", log_len[0], NB);
    check("A5 frame_done clk inst0", fd_idx[0], NB);
    check("A5 active clks inst1", log_len[1], 3 * NB);
    check("A5 frame_done clk inst1", fd_idx[1], 3 * NB);

    // 8'hFF on the DIV=3 instance: every bit tripled
    send(8'hFF);
    base = PAR_EN ? 14'b10101111111100 : 14'b01010111111110;
    tripled = '0;
    for (int k = NB - 1; k >= 0; k--) tripled = {tripled[60:0], {3{base[k]}}};
    check("FF bits inst1", packed_log(1, 3 * NB), tripled);
    check("FF frame_done clk inst1", fd_idx[1], 3 * NB);

    // 8'h01 on the LSB-first instance
    send(8'h01);
    base = PAR_EN ? 14'b10101000000010 : 14'b01010100000000;
    check("01 bits inst2", packed_log(2, NB), base);

    // 8'h07: parity bit 1 when enabled
    send(8'h07);
    base = PAR_EN ? 14'b10100000011110 : 14'b01010000001110;
    check("07 bits inst0", packed_log(0, NB), base);

    // Held code_valid: 8'h81 then 8'h3C back-to-back
    wait_all_ready("b2b");
    prev = acc_num[0];
    code = 8'h81;
    code_valid = 1'b1;
    wait_accept(prev);
    code = 8'h3C;
    wait_accept(prev + 1);
    code_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b idle gap inst0", last_gap[0], 1);
    wait_all_ready("b2b end");
    base = PAR_EN ? 14'b10100011110000 : 14'b01010001111000;
    check("3C bits inst0", packed_log(0, NB), base);

    // Reset in the middle of the data field
    wait_all_ready("rst");
    code = 8'hC3;
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("mid-frame reset inst%0d", g),
            {ready_w[g], bit_w[g], act_w[g], done_w[g]}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready right after release", ready_w[0], 1'b0);
    @(posedge clk); #1;
    check("ready one clk after release", ready_w[0], 1'b1);
    send(8'hA5);
    base = PAR_EN ? 14'b10101010010100 : 14'b01010101001010;
    check("A5 after reset inst0", packed_log(0, NB), base);

    // Random traffic, checked every cycle by the models
    repeat (2500) begin
      @(posedge clk); #1;
      code_valid = ($urandom_range(0, 3) != 0);
      code = 8'($urandom);
    end
    code_valid = 1'b0;
    wait_all_ready("random end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
